// File: rtl/pwm_timer_ctrl_if.sv
// Configuration bus and PWM timer outputs bundled for pwm_timer_ctrl.
// master drives the register writes, slave is the timer block.
interface pwm_timer_ctrl_if;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        pwm_en;
    logic [15:0] period;
    logic [7:0]  functions;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [15:0] count_val;
    logic        ovf;
    logic        running;

    modport master (
        output cfg_wr, cfg_addr, cfg_wdata,
        input  pwm_en, period, functions, compare1, compare2,
        input  count_val, ovf, running
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_wdata,
        output pwm_en, period, functions, compare1, compare2,
        output count_val, ovf, running
    );
endinterface

// File: rtl/pwm_timer_ctrl.sv
// PWM timer controller: shadow/active register pairs, prescaled counter,
// and an IDLE/RUN/DONE sequencer with one-shot support.
module pwm_timer_ctrl (
    input logic             clk,
    input logic             rst_n,
    pwm_timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        oneshot_q, oneshot_d;
    logic [15:0] sh_period_q, sh_period_d;
    logic [7:0]  sh_presc_q, sh_presc_d;
    logic [7:0]  sh_func_q, sh_func_d;
    logic [15:0] sh_cmp1_q, sh_cmp1_d;
    logic [15:0] sh_cmp2_q, sh_cmp2_d;
    logic [15:0] act_period_q, act_period_d;
    logic [7:0]  act_presc_q, act_presc_d;
    logic [7:0]  act_func_q, act_func_d;
    logic [15:0] act_cmp1_q, act_cmp1_d;
    logic [15:0] act_cmp2_q, act_cmp2_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  pre_q, pre_d;
    logic        ovf_q, ovf_d;
    logic        pwm_en_q, pwm_en_d;

    logic wr_ctrl, clr, en_wr1, tick, load;

    always_comb begin
        wr_ctrl = bus.cfg_wr && (bus.cfg_addr == 3'd0);
        clr     = wr_ctrl && bus.cfg_wdata[2];
        en_wr1  = wr_ctrl && bus.cfg_wdata[0];
        tick    = (pre_q == act_presc_q);
        load    = 1'b0;

        state_d      = state_q;
        en_d         = en_q;
        oneshot_d    = oneshot_q;
        sh_period_d  = sh_period_q;
        sh_presc_d   = sh_presc_q;
        sh_func_d    = sh_func_q;
        sh_cmp1_d    = sh_cmp1_q;
        sh_cmp2_d    = sh_cmp2_q;
        act_period_d = act_period_q;
        act_presc_d  = act_presc_q;
        act_func_d   = act_func_q;
        act_cmp1_d   = act_cmp1_q;
        act_cmp2_d   = act_cmp2_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        ovf_d        = 1'b0;

        if (bus.cfg_wr) begin
            case (bus.cfg_addr)
                3'd0: begin
                    en_d      = bus.cfg_wdata[0];
                    oneshot_d = bus.cfg_wdata[1];
                end
                3'd1:    sh_period_d = bus.cfg_wdata;
                3'd2:    sh_presc_d  = bus.cfg_wdata[7:0];
                3'd3:    sh_func_d   = bus.cfg_wdata[7:0];
                3'd4:    sh_cmp1_d   = bus.cfg_wdata;
                3'd5:    sh_cmp2_d   = bus.cfg_wdata;
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                load  = 1'b1;
                cnt_d = '0;
                pre_d = '0;
                if (en_q) state_d = RUN;
            end
            RUN: begin
                if (!en_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                end else if (clr) begin
                    cnt_d = '0;
                    pre_d = '0;
                    load  = 1'b1;
                end else if (tick) begin
                    pre_d = '0;
                    if (cnt_q == act_period_q) begin
                        cnt_d = '0;
                        ovf_d = 1'b1;
                        load  = 1'b1;
                        // A CTRL write in the wrap cycle overrides the one-shot stop
                        if (oneshot_q && !en_wr1) begin
                            state_d = DONE;
                            if (!wr_ctrl) en_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    pre_d = pre_q + 8'd1;
                end
            end
            DONE: begin
                load    = 1'b1;
                cnt_d   = '0;
                pre_d   = '0;
                state_d = en_wr1 ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shadow values are the pre-write ones, so same-cycle writes wait a wrap
        if (load) begin
            act_period_d = sh_period_q;
            act_presc_d  = sh_presc_q;
            act_func_d   = sh_func_q;
            act_cmp1_d   = sh_cmp1_q;
            act_cmp2_d   = sh_cmp2_q;
        end

        pwm_en_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            oneshot_q    <= 1'b0;
            sh_period_q  <= '0;
            sh_presc_q   <= '0;
            sh_func_q    <= '0;
            sh_cmp1_q    <= '0;
            sh_cmp2_q    <= '0;
            act_period_q <= '0;
            act_presc_q  <= '0;
            act_func_q   <= '0;
            act_cmp1_q   <= '0;
            act_cmp2_q   <= '0;
            cnt_q        <= '0;
            pre_q        <= '0;
            ovf_q        <= 1'b0;
            pwm_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            oneshot_q    <= oneshot_d;
            sh_period_q  <= sh_period_d;
            sh_presc_q   <= sh_presc_d;
            sh_func_q    <= sh_func_d;
            sh_cmp1_q    <= sh_cmp1_d;
            sh_cmp2_q    <= sh_cmp2_d;
            act_period_q <= act_period_d;
            act_presc_q  <= act_presc_d;
            act_func_q   <= act_func_d;
            act_cmp1_q   <= act_cmp1_d;
            act_cmp2_q   <= act_cmp2_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            ovf_q        <= ovf_d;
            pwm_en_q     <= pwm_en_d;
        end
    end

    assign bus.pwm_en    = pwm_en_q;
    assign bus.period    = act_period_q;
    assign bus.functions = act_func_q;
    assign bus.compare1  = act_cmp1_q;
    assign bus.compare2  = act_cmp2_q;
    assign bus.count_val = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.running   = (state_q == RUN);
endmodule

// File: doc/pwm_timer_ctrl.md
PWM_TIMER_CTRL -- requirements
Module: pwm_timer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed as follows.
- clk  input  1  peripheral clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_wr  input  1  single-cycle register write strobe.
- cfg_addr  input  3  register select.
- cfg_wdata  input  16  write data.
- pwm_en  output  1  enable to the PWM generator.
- period  output  16  active period.
- functions  output  8  active alignment/mode bits.
- compare1  output  16  active compare 1.
- compare2  output  16  active compare 2.
- count_val  output  16  timer count.
- ovf  output  1  one-cycle pulse on period wrap.
- running  output  1  high in state RUN.

REQ-002 The register map SHALL be as follows; cfg_addr 6-7 are ignored.
- addr 0, CTRL: bit0 EN, bit1 ONESHOT, bit2 CNT_CLR (self-clearing, write-only).
- addr 1, PERIOD[15:0].
- addr 2, PRESCALE[7:0]; the tick rate is clk/(PRESCALE+1).
- addr 3, FUNCTIONS[7:0].
- addr 4, COMPARE1.
- addr 5, COMPARE2.

REQ-003 Fields narrower than 16 bits SHALL take the low bits of cfg_wdata and ignore the rest.

Function
REQ-004 PERIOD, PRESCALE, FUNCTIONS, COMPARE1 and COMPARE2 SHALL be shadow registers, written on the clock edge where cfg_wr is high.

REQ-005 The period, functions, compare1 and compare2 outputs SHALL come from active registers, never directly from the shadows. The active prescale value is internal.

REQ-006 There SHALL be three FSM states: IDLE, RUN and DONE.

REQ-007 Behaviour in IDLE and DONE:
- active registers are loaded from the shadows every cycle;
- count_val = 0, prescaler = 0, pwm_en = 0.

REQ-008 IDLE SHALL go to RUN on the cycle after EN reads 1.

REQ-009 On entering RUN, the active registers SHALL hold the shadow values present on the entry edge, and count_val SHALL be 0.

REQ-010 In RUN, pwm_en SHALL be 1 and running SHALL be 1.

REQ-011 In RUN, a tick SHALL occur when prescaler == active PRESCALE; the prescaler then returns to 0, otherwise it increments.

REQ-012 On a tick with count_val != active PERIOD, count_val SHALL increment by 1.

REQ-013 On a tick with count_val == active PERIOD:
- count_val returns to 0;
- ovf pulses for exactly one cycle;
- all active registers load from the shadows.

REQ-014 With PERIOD = 0, count_val SHALL stay 0 and ovf SHALL pulse on every tick.

REQ-015 Loading active registers on a wrap SHALL take shadow values from before any same-cycle write; a same-cycle write reaches the active registers at the next wrap.

REQ-016 A wrap with ONESHOT = 1 SHALL go to DONE and clear EN in the same edge.

REQ-017 DONE SHALL go to IDLE on the next cycle unless EN is written to 1 in that cycle; in that case it goes to RUN.

REQ-018 EN = 0 while in RUN (by write) SHALL return the FSM to IDLE on the next edge. count_val and prescaler clear to 0, with no ovf.

REQ-019 Writing CNT_CLR = 1 SHALL, on that edge:
- clear count_val and the prescaler;
- load the active registers from the shadows;
- leave the state unchanged and produce no ovf.

REQ-020 The same CTRL write SHALL update EN and ONESHOT as well as applying CNT_CLR.

REQ-021 A CTRL write in the wrap cycle SHALL take precedence over the ONESHOT auto-clear of EN.

REQ-022 A wrap-to-DONE in the same cycle as an EN write of 1 SHALL stay in RUN.

REQ-023 count_val SHALL never exceed active PERIOD. Arithmetic is unsigned 16-bit and 0xFFFF is a legal period.

REQ-024 All outputs SHALL be registered, except running, which is decoded from the state.

Reset
REQ-025 While rst_n is low, regardless of clk:
- state = IDLE;
- CTRL, all shadow and active registers, count_val and prescaler = 0;
- pwm_en, ovf, running = 0.

REQ-026 Reset asserted mid-run SHALL abort immediately, with no ovf. Operation resumes only after a new EN write following rst_n deassertion.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- PERIOD=3, PRESCALE=0, EN=1 -> count_val 0,1,2,3,0,...; ovf high each cycle count_val goes 3->0; pwm_en=1.
- PRESCALE=2, PERIOD=1 -> count_val changes every 3rd clk; ovf once per 6 clk.
- While running PERIOD=9, write PERIOD=4 mid-period -> period output stays 9 until the wrap, then reads 4; the next wrap occurs at count_val=4.
- ONESHOT=1, EN=1, PERIOD=2 -> one ovf; state DONE then IDLE; pwm_en falls the edge after the wrap; EN reads 0.
- PERIOD=0 -> count_val stays 0; ovf every tick. CNT_CLR at count_val=5 (PERIOD=9) -> count_val=0 next cycle; no ovf; running stays 1.
- rst_n pulsed low at count_val=7 -> all outputs 0 asynchronously; after release the block stays IDLE until EN is written.
